// File: rtl/tsc_phase_scheduler_if.sv
// Sensor/lamp-side bundle of the intersection phase scheduler.
// Preemption signals exist only when TSC_PREEMPT_EN is defined.
interface tsc_phase_scheduler_if #(
    parameter int N_APPR = 4
);
    localparam int IW = $clog2(N_APPR);

    logic                  tick;
    logic [N_APPR-1:0]     req;
    logic [2*N_APPR-1:0]   lights;
    logic [IW-1:0]         active_idx;
    logic                  phase_start;
`ifdef TSC_PREEMPT_EN
    logic                  preempt;
    logic [IW-1:0]         preempt_idx;

    modport master (
        output tick, req, preempt, preempt_idx,
        input  lights, active_idx, phase_start
    );
    modport slave (
        input  tick, req, preempt, preempt_idx,
        output lights, active_idx, phase_start
    );
`else
    modport master (
        output tick, req,
        input  lights, active_idx, phase_start
    );
    modport slave (
        input  tick, req,
        output lights, active_idx, phase_start
    );
`endif
endinterface

// File: rtl/tsc_phase_scheduler.sv
// Round-robin green arbitration with min/max green, yellow and all-red sequencing.
// Optional emergency preemption is compiled in with TSC_PREEMPT_EN.
module tsc_phase_scheduler #(
    parameter int N_APPR    = 4,
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 30,
    parameter int YELLOW    = 4,
    parameter int ALL_RED   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tsc_phase_scheduler_if.slave bus
);
    localparam int IW   = $clog2(N_APPR);
    // One shared interval counter, sized for the longest interval it must hold.
    localparam int CMAX = (MAX_GREEN > YELLOW)
                        ? ((MAX_GREEN > ALL_RED) ? MAX_GREEN : ALL_RED)
                        : ((YELLOW > ALL_RED) ? YELLOW : ALL_RED);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;
    localparam logic [1:0] ST_CLEAR  = 2'd3;

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;

    if (N_APPR < 2 || N_APPR > 8 || MIN_GREEN < 1 || MAX_GREEN <= MIN_GREEN ||
        YELLOW < 1 || ALL_RED < 1) begin : g_param_check
        $error("tsc_phase_scheduler: illegal parameter set");
    end

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_adv, cnt_lim;
    logic [IW-1:0]       ptr_q, ptr_d, active_q, active_d;
    logic [N_APPR-1:0]   req_q, active_mask;
    logic [2*N_APPR-1:0] lights_q, lights_d;
    logic                phase_start_q, phase_start_d;

    logic [IW-1:0]       rr_winner, winner, winner_next;
    logic [IW:0]         rr_cand;
    logic                rr_found, win_found;
    logic                others_pending, own_req, exit_rr, green_exit;

    function automatic logic [2*N_APPR-1:0] lamp_map(input logic [1:0] st,
                                                     input logic [IW-1:0] idx);
        lamp_map = {N_APPR{LAMP_RED}};
        for (int i = 0; i < N_APPR; i++) begin
            if (IW'(i) == idx) begin
                if (st == ST_GREEN)       lamp_map[2*i +: 2] = LAMP_GREEN;
                else if (st == ST_YELLOW) lamp_map[2*i +: 2] = LAMP_YELLOW;
            end
        end
    endfunction

    // First set request scanning upward from the pointer, modulo N_APPR.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rr_found  = 1'b0;
        rr_winner = ptr_q;
        rr_cand   = '0;
        for (int i = 0; i < N_APPR; i++) begin
            rr_cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (rr_cand >= (IW+1)'(N_APPR)) rr_cand = rr_cand - (IW+1)'(N_APPR);
            if (!rr_found && req_q[rr_cand[IW-1:0]]) begin
                rr_found  = 1'b1;
                rr_winner = rr_cand[IW-1:0];
            end
        end
    end

    assign active_mask    = {{(N_APPR-1){1'b0}}, 1'b1} << active_q;
    assign others_pending = |(req_q & ~active_mask);
    assign own_req        = |(req_q & active_mask);

    always_comb begin
        case (state_q)
            ST_GREEN:  cnt_lim = CW'(MAX_GREEN);
            ST_YELLOW: cnt_lim = CW'(YELLOW);
            ST_CLEAR:  cnt_lim = CW'(ALL_RED);
            default:   cnt_lim = '0;
        endcase
    end

    // Count including the current tick, so an interval of K ticks occupies exactly K tick-cycles.
    assign cnt_adv = (bus.tick && cnt_q < cnt_lim) ? cnt_q + CW'(1) : cnt_q;

    assign exit_rr = others_pending && (cnt_adv >= CW'(MIN_GREEN)) &&
                     (!own_req || cnt_adv >= CW'(MAX_GREEN));

`ifdef TSC_PREEMPT_EN
    assign winner     = bus.preempt ? bus.preempt_idx : rr_winner;
    assign win_found  = bus.preempt | rr_found;
    assign green_exit = bus.preempt ? (bus.preempt_idx != active_q) : exit_rr;
`else
    assign winner     = rr_winner;
    assign win_found  = rr_found;
    assign green_exit = exit_rr;
`endif

    assign winner_next = (winner == IW'(N_APPR - 1)) ? '0 : winner + IW'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_adv;
        active_d      = active_q;
        ptr_d         = ptr_q;
        phase_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (win_found) begin
                    state_d       = ST_GREEN;
                    active_d      = winner;
                    ptr_d         = winner_next;
                    phase_start_d = 1'b1;
                end
            end
            ST_GREEN: begin
                if (green_exit) begin
                    state_d = ST_YELLOW;
                    cnt_d   = '0;
                end
            end
            ST_YELLOW: begin
                if (cnt_adv >= CW'(YELLOW)) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_adv >= CW'(ALL_RED)) begin
                    cnt_d = '0;
                    if (win_found) begin
                        state_d       = ST_GREEN;
                        active_d      = winner;
                        ptr_d         = winner_next;
                        phase_start_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
        lights_d = lamp_map(state_d, active_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ptr_q         <= '0;
            active_q      <= '0;
            req_q         <= '0;
            lights_q      <= {N_APPR{LAMP_RED}};
            phase_start_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            active_q      <= active_d;
            req_q         <= bus.req;
            lights_q      <= lights_d;
            phase_start_q <= phase_start_d;
        end
    end

    assign bus.lights      = lights_q;
    assign bus.active_idx  = active_q;
    assign bus.phase_start = phase_start_q;
endmodule

// File: tb/tb_tsc_phase_scheduler.sv
// Scoreboard bench for tsc_phase_scheduler: stimulus queues expected grants, a monitor checks each phase_start.
// Preemption scenario is exercised when TSC_PREEMPT_EN is defined.
module tb_tsc_phase_scheduler;
    localparam int N = 4;

    typedef struct {
        logic [1:0] idx;
        int         cyc;
    } grant_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     s0;
    grant_t exp_q[$];
    grant_t mon_e;

    tsc_phase_scheduler_if #(.N_APPR(N)) bus ();

    tsc_phase_scheduler #(
        .N_APPR(N), .MIN_GREEN(8), .MAX_GREEN(30), .YELLOW(4), .ALL_RED(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lamp word with every approach red except idx showing code.
    function automatic logic [7:0] lamp(input int idx, input logic [1:0] code);
        lamp = 8'hAA;
        for (int i = 0; i < N; i++) if (i == idx) lamp[2*i +: 2] = code;
    endfunction

    task automatic expect_grant(input logic [1:0] idx, input int at);
        grant_t g;
        g.idx = idx;
        g.cyc = at;
        exp_q.push_back(g);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step(1);
    endtask

    always @(negedge clk) begin
        if (bus.phase_start) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_grant: got idx %0d at cycle %0d, required no phase_start",
                         bus.active_idx, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("grant_idx", 32'(bus.active_idx), 32'(mon_e.idx));
                check("grant_cycle", cyc, mon_e.cyc);
                check("grant_lights", 32'(bus.lights), 32'(lamp(mon_e.idx, 2'b00)));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        bus.tick = 1'b1;
        bus.req  = '0;
`ifdef TSC_PREEMPT_EN
        bus.preempt     = 1'b0;
        bus.preempt_idx = '0;
`endif
        step(3);
        check("rst_lights", 32'(bus.lights), 32'h0000_00AA);
        check("rst_active", 32'(bus.active_idx), 0);
        check("rst_phase_start", 32'(bus.phase_start), 0);
        rst_n = 1'b1;

        // Idle with no requests: all red, any phase_start is flagged by the monitor.
        step(50);
        check("idle_lights", 32'(bus.lights), 32'h0000_00AA);

        // Single request on approach 2: green two cycles later, rests after the request drops.
        expect_grant(2'd2, cyc + 2);
        bus.req = 4'b0100;
        step(5);
        bus.req = 4'b0000;
        step(60);
        check("rest_lights", 32'(bus.lights), 32'(lamp(2, 2'b00)));
        check("rest_active", 32'(bus.active_idx), 2);

        // Competing request forces yellow, then asynchronous reset mid-yellow.
        bus.req = 4'b0001;
        step(2);
        check("yellow_lights", 32'(bus.lights), 32'(lamp(2, 2'b01)));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_lights", 32'(bus.lights), 32'h0000_00AA);
        check("async_rst_active", 32'(bus.active_idx), 0);
        check("async_rst_phase_start", 32'(bus.phase_start), 0);
        bus.req = 4'b1011;
        step(2);
        rst_n = 1'b1;

        // Contention 1011 from pointer 0: 30 green + 4 yellow + 2 all-red per phase.
        s0 = cyc + 2;
        expect_grant(2'd0, s0);
        expect_grant(2'd1, s0 + 36);
        expect_grant(2'd3, s0 + 72);
        expect_grant(2'd0, s0 + 108);
        step_to(s0 + 29);
        check("max_green_last", 32'(bus.lights), 32'(lamp(0, 2'b00)));
        step_to(s0 + 31);
        check("max_green_yellow", 32'(bus.lights), 32'(lamp(0, 2'b01)));
        step_to(s0 + 35);
        check("all_red_clear", 32'(bus.lights), 32'h0000_00AA);

        // Gap-out: own request drops at elapsed 3, yellow still waits for MIN_GREEN.
        step_to(s0 + 108);
        bus.req = 4'b0011;
        step(3);
        bus.req = 4'b0010;
        step_to(s0 + 115);
        check("gap_min_green", 32'(bus.lights), 32'(lamp(0, 2'b00)));
        step(1);
        check("gap_yellow", 32'(bus.lights), 32'(lamp(0, 2'b01)));
        expect_grant(2'd1, s0 + 122);

`ifdef TSC_PREEMPT_EN
        // Preempt to approach 3 while approach 1 is at elapsed 2.
        step_to(s0 + 124);
        bus.preempt     = 1'b1;
        bus.preempt_idx = 2'd3;
        expect_grant(2'd3, s0 + 131);
        step(1);
        check("preempt_yellow", 32'(bus.lights), 32'(lamp(1, 2'b01)));
        step_to(s0 + 132);
        bus.req = 4'b0011;
        step(60);
        check("preempt_hold", 32'(bus.lights), 32'(lamp(3, 2'b00)));
        bus.preempt = 1'b0;
        expect_grant(2'd0, cyc + 7);
        step(10);
        bus.req = 4'b0000;
`else
        step_to(s0 + 130);
        bus.req = 4'b0000;
`endif
        step(20);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tsc_phase_scheduler.md
# tsc_phase_scheduler

- Round-robin phase scheduler for a multi-approach signalised intersection.
- The green right-of-way is one shared resource. The block grants it to one of `N_APPR` requesting approaches at a time.
- Every handover is sequenced through minimum green, maximum green, yellow and all-red clearance intervals.
- Sits between the per-approach vehicle sensors and the lamp drivers. It replaces fixed two-road sequencing with fair multi-requester arbitration.

## Interface
Parameters:
- `N_APPR`, 4: number of approaches, 2..8.
- `MIN_GREEN`, 8: minimum green duration in ticks, ≥1.
- `MAX_GREEN`, 30: maximum green duration, in ticks, while other requests are pending. Must be > `MIN_GREEN`.
- `YELLOW`, 4: yellow duration in ticks, ≥1.
- `ALL_RED`, 2: all-red clearance duration in ticks, ≥1.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `tick`, in, 1: timebase enable. All interval counters advance only on cycles with `tick`=1.
- `req`, in, `N_APPR`: level vehicle-presence request, one bit per approach.
- `lights`, out, 2·`N_APPR`: lamp code for approach i in bits [2i+1:2i]. Codes: 00 green, 01 yellow, 10 red. 11 is never driven.
- `active_idx`, out, clog2(`N_APPR`): approach currently holding or last granted right-of-way.
- `phase_start`, out, 1: one-cycle pulse on the cycle a new green begins.
- `preempt`, in, 1: present only with `TSC_PREEMPT_EN`.
- `preempt_idx`, in, clog2(`N_APPR`): present only with `TSC_PREEMPT_EN`.

## Operation
- The FSM has four states: IDLE, GREEN, YELLOW, CLEAR.
- Reset values:
  - state IDLE, elapsed counter 0.
  - round-robin pointer 0, `active_idx` 0.
  - all `lights` 10, `phase_start` 0.
- Arbitration:
  - The winner is the first set `req` bit scanning upward from the pointer, modulo `N_APPR`.
  - When a green begins, the pointer is set to winner+1, wrapping `N_APPR`-1 to 0.
- IDLE: all red. When any `req` is 1, go to GREEN for the winner: `active_idx` := winner, elapsed := 0, `phase_start` := 1.
- GREEN:
  - Active approach shows 00; all others show 10.
  - Elapsed counter increments on each tick and saturates at `MAX_GREEN`.
  - "Others pending" means any `req` bit other than `active_idx` is set.
  - Exit to YELLOW when others are pending AND elapsed ≥ `MIN_GREEN` AND either `req[active_idx]`=0 or elapsed ≥ `MAX_GREEN`.
  - With no others pending, the green rests indefinitely, even if its own request has dropped.
- YELLOW: active approach shows 01. After `YELLOW` ticks, go to CLEAR.
- CLEAR:
  - All approaches show 10.
  - After `ALL_RED` ticks, arbitrate again. With a winner, go to GREEN with `phase_start`. With none, go to IDLE.
  - The approach just served is eligible only after all others, because the pointer has already advanced past it.
- Requests are sampled every cycle. A request that appears and drops entirely within YELLOW or CLEAR is not remembered.
- An asynchronous reset in any state immediately forces all red and IDLE. No yellow is shown.

## Timing
- All outputs are registered.
- `lights` changes one cycle after the clock edge on which the transition condition is true.
- Interval lengths, in tick-cycles: green ≥ `MIN_GREEN`, yellow = `YELLOW` exactly, all-red = `ALL_RED` exactly.
- With `tick` held at 1, the latency from a `req` edge in IDLE to green is 2 cycles: one register stage for sampling, one for the state register.
- The minimum handover from green to the next green is `YELLOW`+`ALL_RED`+1 cycles with `tick` held at 1.
- Counter width is clog2(`MAX_GREEN`+1). The counter never wraps.
- Ties between simultaneous requests are resolved only by pointer order.

## Configuration
- `TSC_PREEMPT_EN` defined:
  - The `preempt` and `preempt_idx` ports exist.
  - While `preempt`=1 and `active_idx`≠`preempt_idx`, a current GREEN exits to YELLOW immediately, ignoring `MIN_GREEN`.
  - At the end of CLEAR, and in IDLE, the winner is forced to `preempt_idx` regardless of `req`. The pointer is then set to `preempt_idx`+1.
  - While `preempt`=1 and `active_idx`=`preempt_idx`, GREEN never exits.
  - Yellow and all-red are never shortened.
- Undefined: the ports are absent and the block behaves as pure round-robin.

## Test plan
- Reset then idle: assert `rst_n`=0, release it, keep `req`=0 for 50 cycles → all `lights`=10, `phase_start` never pulses.
- Single request, `tick`=1, `req`=0b0100 → approach 2 goes green 2 cycles later with one `phase_start` pulse. Approach 2 stays green indefinitely after `req` drops, since no other request is pending.
- Contention: `req`=0b1011 held with pointer 0 → greens in order 0,1,3,0. Each green lasts exactly `MAX_GREEN`=30 ticks, followed by 4 yellow and 2 all-red ticks.
- Early gap-out: approach 0 green, `req[0]` drops at elapsed 3 while `req[1]`=1 → yellow starts at elapsed 8 (`MIN_GREEN`), not earlier.
- Reset mid-yellow: `rst_n` low during YELLOW → `lights` all 10 asynchronously, state IDLE, pointer 0.
- `TSC_PREEMPT_EN`: approach 1 green at elapsed 2, `preempt`=1, `preempt_idx`=3 → yellow next cycle, then 2 all-red ticks, then approach 3 green held while `preempt`=1 even with `req`=0b0011.
